// File: rtl/pulse_50_hz.sv
// pulse_50_hz: free-running divider, one PULSE_WIDTH_CYCLES strobe every CLK_FREQ_HZ/PULSE_FREQ_HZ clocks.
// Optional macro PULSE_50_HZ_SYNC_EN adds SYNC_IN to re-phase the divider to an external reference.
module pulse_50_hz #(
  parameter int unsigned CLK_FREQ_HZ        = 3276800,
  parameter int unsigned PULSE_FREQ_HZ      = 50,
  parameter int unsigned PULSE_WIDTH_CYCLES = 1
) (
  input  logic CLK,
  input  logic nRST,
`ifdef PULSE_50_HZ_SYNC_EN
  input  logic SYNC_IN,
`endif
  output logic PULSE_50_HZ
);

  localparam int unsigned FREQ_SAFE =
    (PULSE_FREQ_HZ == 0) ? 1 : PULSE_FREQ_HZ;
  localparam int unsigned DIVIDE = CLK_FREQ_HZ / FREQ_SAFE;
  localparam int unsigned REM    = CLK_FREQ_HZ % FREQ_SAFE;
  localparam int unsigned CW     =
    (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  localparam logic [CW-1:0] LAST  = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] WIDTH = CW'(PULSE_WIDTH_CYCLES);

  if (PULSE_FREQ_HZ == 0 || REM != 0) begin : g_bad_ratio
    $error("pulse_50_hz: CLK_FREQ_HZ not a multiple of PULSE_FREQ_HZ");
  end

  if (PULSE_WIDTH_CYCLES < 1) begin : g_bad_width_lo
    $error("pulse_50_hz: PULSE_WIDTH_CYCLES must be >= 1");
  end

  if (PULSE_WIDTH_CYCLES >= DIVIDE) begin : g_bad_width_hi
    $error("pulse_50_hz: PULSE_WIDTH_CYCLES must be < DIVIDE");
  end

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          pulse_nxt;
  logic          sync_edge;

`ifdef PULSE_50_HZ_SYNC_EN
  // [0],[1] synchronise the async reference; [2] is the edge-detect history
  logic [2:0] sync_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], SYNC_IN};
    end
  end

  assign sync_edge = sync_q[1] & ~sync_q[2];
`else
  assign sync_edge = 1'b0;
`endif

  // A sync edge landing on the natural wrap also yields 0: one strobe only
  always_comb begin
    count_nxt = count + CW'(1);
    if (count == LAST || sync_edge) begin
      count_nxt = '0;
    end
  end

  always_comb begin
    pulse_nxt = (count < WIDTH);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count       <= '0;
      PULSE_50_HZ <= 1'b0;
    end else begin
      count       <= count_nxt;
      PULSE_50_HZ <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_50_hz.sv
// Bench for pulse_50_hz: two scaled-down instances (divide 64 width 1, divide 30 width 4).
// Define PULSE_50_HZ_SYNC_EN to also exercise SYNC_IN re-phasing.
module tb_pulse_50_hz;

  localparam int DA = 64;
  localparam int WA = 1;
  localparam int DB = 30;
  localparam int WB = 4;
  localparam int SEC_A = 3200;

  logic clk;
  logic rst_n;
  logic sync_a;
  logic sync_b;
  logic pa;
  logic pb;

  int checks;
  int errors;
  int k;

  pulse_50_hz #(
    .CLK_FREQ_HZ(3200),
    .PULSE_FREQ_HZ(50),
    .PULSE_WIDTH_CYCLES(WA)
  ) dut_a (
    .CLK(clk),
    .nRST(rst_n),
`ifdef PULSE_50_HZ_SYNC_EN
    .SYNC_IN(sync_a),
`endif
    .PULSE_50_HZ(pa)
  );

  pulse_50_hz #(
    .CLK_FREQ_HZ(3000),
    .PULSE_FREQ_HZ(100),
    .PULSE_WIDTH_CYCLES(WB)
  ) dut_b (
    .CLK(clk),
    .nRST(rst_n),
`ifdef PULSE_50_HZ_SYNC_EN
    .SYNC_IN(sync_b),
`endif
    .PULSE_50_HZ(pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   k;
    logic a;
    logic b;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  int   last_rise[2];
  int   rises[2];
  int   bad_sp[2];
  int   bad_w[2];
  int   first_rise[2];
  int   dv[2];
  int   wv[2];
  logic cur[2];
  logic prv[2];
  int   p;
  int   lat;
  int   n;

  initial begin
    checks = 0;
    errors = 0;
    k = 0;
    rst_n = 1'b0;
    sync_a = 1'b0;
    sync_b = 1'b0;
    dv[0] = DA; dv[1] = DB;
    wv[0] = WA; wv[1] = WB;

    tbl[0]  = '{1,   1'b1, 1'b1};
    tbl[1]  = '{2,   1'b0, 1'b1};
    tbl[2]  = '{4,   1'b0, 1'b1};
    tbl[3]  = '{5,   1'b0, 1'b0};
    tbl[4]  = '{30,  1'b0, 1'b0};
    tbl[5]  = '{31,  1'b0, 1'b1};
    tbl[6]  = '{34,  1'b0, 1'b1};
    tbl[7]  = '{35,  1'b0, 1'b0};
    tbl[8]  = '{64,  1'b0, 1'b1};
    tbl[9]  = '{65,  1'b1, 1'b0};
    tbl[10] = '{66,  1'b0, 1'b0};
    tbl[11] = '{121, 1'b0, 1'b1};
    tbl[12] = '{129, 1'b1, 1'b0};

    // reset state, held across clocks
    repeat (4) @(posedge clk);
    #1;
    chk("reset_a", pa, 1'b0);
    chk("reset_b", pb, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) tick();
      chk($sformatf("vec_a_k%0d", tbl[i].k), pa, tbl[i].a);
      chk($sformatf("vec_b_k%0d", tbl[i].k), pb, tbl[i].b);
    end

    // one scaled second: edge count, spacing, width
    do_reset();
    for (int j = 0; j < 2; j++) begin
      last_rise[j] = -1;
      first_rise[j] = -1;
      rises[j] = 0;
      bad_sp[j] = 0;
      bad_w[j] = 0;
      prv[j] = 1'b0;
    end
    for (int e = 1; e <= SEC_A + 1; e++) begin
      tick();
      cur[0] = pa;
      cur[1] = pb;
      for (int j = 0; j < 2; j++) begin
        if (cur[j] && !prv[j]) begin
          if (e <= SEC_A) rises[j]++;
          if (first_rise[j] < 0) first_rise[j] = e;
          if (last_rise[j] >= 0 && e - last_rise[j] != dv[j])
            bad_sp[j]++;
          last_rise[j] = e;
        end
        if (!cur[j] && prv[j] && e - last_rise[j] != wv[j])
          bad_w[j]++;
        prv[j] = cur[j];
      end
    end
    chk_int("sec_rises_a", rises[0], 50);
    chk_int("first_rise_a", first_rise[0], 1);
    chk_int("spacing_a", bad_sp[0], 0);
    chk_int("width_a", bad_w[0], 0);
    chk_int("edge51_a", last_rise[0], SEC_A + 1);
    chk_int("sec_rises_b", rises[1], 107);
    chk_int("first_rise_b", first_rise[1], 1);
    chk_int("spacing_b", bad_sp[1], 0);
    chk_int("width_b", bad_w[1], 0);

    // reset asserted mid-strobe drops output without a clock edge
    do_reset();
    tick();
    chk("pre_rst_a_high", pa, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_drop_a", pa, 1'b0);
    chk("async_drop_b", pb, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 32) tick();
    chk("pre_rst_b_high", pb, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_drop_b2", pb, 1'b0);
    repeat (3) tick();
    chk("hold_rst_a", pa, 1'b0);
    chk("hold_rst_b", pb, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tick();
    chk("restart_a_k1", pa, 1'b1);
    chk("restart_b_k1", pb, 1'b1);
    while (k < 64) tick();
    chk("restart_a_k64", pa, 1'b0);
    tick();
    chk("restart_a_k65", pa, 1'b1);

`ifdef PULSE_50_HZ_SYNC_EN
    // sync mid-period re-phases the strobe
    do_reset();
    while (k < 31) tick();
    @(negedge clk);
    sync_a = 1'b1;
    p = -1;
    for (int e = 0; e < 10 && p < 0; e++) begin
      tick();
      if (k == 34) sync_a = 1'b0;
      if (pa) p = k;
    end
    if (p < 0) begin
      chk_int("sync_timeout", 0, 1);
      p = 35;
    end
    lat = p - 31;
    chk("sync_latency", (lat >= 3 && lat <= 4), 1'b1);
    sync_a = 1'b0;
    n = 0;
    for (int e = 1; e <= DA; e++) begin
      tick();
      if (pa && e < DA) n++;
    end
    chk_int("sync_no_early", n, 0);
    chk("sync_next_period", pa, 1'b1);

    // sync edge landing on the natural wrap: single strobe
    p = k;
    while (k < p + 60) tick();
    @(negedge clk);
    sync_a = 1'b1;
    n = 0;
    for (int e = 0; e < 68; e++) begin
      tick();
      if (k == p + 63) sync_a = 1'b0;
      if (k == p + 64) chk("wrap_strobe", pa, 1'b1);
      if (k == p + 65) chk("wrap_no_double", pa, 1'b0);
      if (pa) n++;
    end
    chk_int("wrap_strobe_count", n, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
